cla_topic_value_alloc: RTL and testbench

- Allocation stage directly downstream of the topic free-pointer list; the only consumer of its free-buffer pops and the only producer of its buffer releases.
- Accepts topic update/delete commands and holds a per-topic table {valid, buffer ptr}.
- Update: pops a fresh buffer, writes the value into the topic value RAM, re-points the topic and releases the old buffer. Delete: releases the buffer and invalidates the entry. A lookup port serves the read side.

---
 rtl/cla_topic_value_alloc.sv | 179 +++++++++++++++++
 tb/tb_cla_topic_value_alloc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_topic_value_alloc.sv
// Topic value allocation stage: per-topic {valid, buffer ptr} table fed by the free-pointer list.
// Updates pop a fresh buffer and release the old one; deletes release and invalidate.
module cla_topic_value_alloc #(
    parameter int unsigned BPTR_NBITS  = 8,
    parameter int unsigned TOPIC_NBITS = 6,
    parameter int unsigned VALUE_NBITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [TOPIC_NBITS-1:0] req_topic,
    input  logic [VALUE_NBITS-1:0] req_value,
    output logic                   req_done,
    output logic                   req_done_hit,
    output logic                   req_abort,
    input  logic                   freeb_init_done,
    input  logic                   freeb_empty,
    input  logic [BPTR_NBITS-1:0]  free_buf_ptr,
    output logic                   free_buf_rd,
    output logic                   rel_buf_valid,
    output logic [BPTR_NBITS-1:0]  rel_buf_ptr,
    output logic                   val_wr,
    output logic [BPTR_NBITS-1:0]  val_wr_addr,
    output logic [VALUE_NBITS-1:0] val_wr_data,
    input  logic                   lkp_valid,
    input  logic [TOPIC_NBITS-1:0] lkp_topic,
    output logic                   lkp_rsp_valid,
    output logic                   lkp_hit,
    output logic [BPTR_NBITS-1:0]  lkp_ptr
);

    localparam int unsigned NumTopics = 1 << TOPIC_NBITS;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e                 state_q, state_d;
    logic                   op_q, op_d;
    logic [TOPIC_NBITS-1:0] topic_q, topic_d;
    logic [VALUE_NBITS-1:0] value_q, value_d;

    logic [NumTopics-1:0]   tbl_valid_q, tbl_valid_d;
    logic [BPTR_NBITS-1:0]  tbl_ptr_q [NumTopics];

    logic                   done_q, done_hit_q, abort_q, rel_valid_q;
    logic [BPTR_NBITS-1:0]  rel_ptr_q;
    logic                   lkp_rsp_valid_q, lkp_hit_q;
    logic [BPTR_NBITS-1:0]  lkp_ptr_q;

    logic                   accept;
    logic                   commit;
    logic                   commit_upd;
    logic                   commit_del;
    logic                   drop;
    logic                   old_valid;
    logic [BPTR_NBITS-1:0]  old_ptr;

    assign old_valid = tbl_valid_q[topic_q];
    assign old_ptr   = tbl_ptr_q[topic_q];

    // An update may only commit once a free buffer is at the head of the list.
    assign commit     = rst_n && freeb_init_done && (state_q == StExec) && (op_q || !freeb_empty);
    assign commit_upd = commit && !op_q;
    assign commit_del = commit && op_q;
    assign drop       = rst_n && !freeb_init_done && (state_q == StExec);

    assign req_ready  = rst_n && freeb_init_done && (state_q == StIdle);
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        topic_d = topic_q;
        value_d = value_q;
        if (!freeb_init_done) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_d    = req_op;
                        topic_d = req_topic;
                        value_d = req_value;
                        state_d = StExec;
                    end
                end
                StExec: begin
                    if (commit) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        tbl_valid_d = tbl_valid_q;
        if (!freeb_init_done) begin
            tbl_valid_d = '0;
        end else if (commit_upd) begin
            tbl_valid_d[topic_q] = 1'b1;
        end else if (commit_del) begin
            tbl_valid_d[topic_q] = 1'b0;
        end
    end

    assign free_buf_rd = commit_upd;
    assign val_wr      = commit_upd;
    assign val_wr_addr = commit_upd ? free_buf_ptr : '0;
    assign val_wr_data = commit_upd ? value_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= 1'b0;
            topic_q     <= '0;
            value_q     <= '0;
            tbl_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            topic_q     <= topic_d;
            value_q     <= value_d;
            tbl_valid_q <= tbl_valid_d;
        end
    end

    // Pointer storage needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (commit_upd) begin
            tbl_ptr_q[topic_q] <= free_buf_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            done_hit_q  <= 1'b0;
            abort_q     <= 1'b0;
            rel_valid_q <= 1'b0;
            rel_ptr_q   <= '0;
        end else begin
            done_q      <= commit;
            done_hit_q  <= commit && old_valid;
            abort_q     <= drop;
            rel_valid_q <= commit && old_valid;
            if (commit && old_valid) begin
                rel_ptr_q <= old_ptr;
            end
        end
    end

    // Lookups read the table before this cycle's commit lands; reinit forces misses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lkp_rsp_valid_q <= 1'b0;
            lkp_hit_q       <= 1'b0;
            lkp_ptr_q       <= '0;
        end else begin
            lkp_rsp_valid_q <= lkp_valid;
            lkp_hit_q       <= 1'b0;
            lkp_ptr_q       <= '0;
            if (lkp_valid && freeb_init_done && tbl_valid_q[lkp_topic]) begin
                lkp_hit_q <= 1'b1;
                lkp_ptr_q <= tbl_ptr_q[lkp_topic];
            end
        end
    end

    assign req_done      = done_q;
    assign req_done_hit  = done_hit_q;
    assign req_abort     = abort_q;
    assign rel_buf_valid = rel_valid_q;
    assign rel_buf_ptr   = rel_ptr_q;
    assign lkp_rsp_valid = lkp_rsp_valid_q;
    assign lkp_hit       = lkp_hit_q;
    assign lkp_ptr       = lkp_ptr_q;

endmodule

// File: tb/tb_cla_topic_value_alloc.sv
// Directed bench for cla_topic_value_alloc: expected events queued at stimulus time,
// popped and compared by a negedge monitor as the DUT emits them.
module tb_cla_topic_value_alloc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_op;
    logic [5:0]  req_topic;
    logic [31:0] req_value;
    logic        req_done, req_done_hit, req_abort;
    logic        freeb_init_done, freeb_empty;
    logic [7:0]  free_buf_ptr;
    logic        free_buf_rd;
    logic        rel_buf_valid;
    logic [7:0]  rel_buf_ptr;
    logic        val_wr;
    logic [7:0]  val_wr_addr;
    logic [31:0] val_wr_data;
    logic        lkp_valid;
    logic [5:0]  lkp_topic;
    logic        lkp_rsp_valid, lkp_hit;
    logic [7:0]  lkp_ptr;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int exp_pops = 0;
    int exp_abort = 0;

    logic [39:0] exp_wr_q [$];
    logic [7:0]  exp_rel_q [$];
    logic        exp_done_q [$];
    logic [8:0]  exp_lkp_q [$];

    always #5 clk = ~clk;

    cla_topic_value_alloc dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_topic       (req_topic),
        .req_value       (req_value),
        .req_done        (req_done),
        .req_done_hit    (req_done_hit),
        .req_abort       (req_abort),
        .freeb_init_done (freeb_init_done),
        .freeb_empty     (freeb_empty),
        .free_buf_ptr    (free_buf_ptr),
        .free_buf_rd     (free_buf_rd),
        .rel_buf_valid   (rel_buf_valid),
        .rel_buf_ptr     (rel_buf_ptr),
        .val_wr          (val_wr),
        .val_wr_addr     (val_wr_addr),
        .val_wr_data     (val_wr_data),
        .lkp_valid       (lkp_valid),
        .lkp_topic       (lkp_topic),
        .lkp_rsp_valid   (lkp_rsp_valid),
        .lkp_hit         (lkp_hit),
        .lkp_ptr         (lkp_ptr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the cycle right after acceptance (DUT in EXEC).
    task automatic send(input logic op, input logic [5:0] topic, input logic [31:0] value);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_topic = topic;
        req_value = value;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic lookup(input logic [5:0] topic, input logic hit, input logic [7:0] ptr);
        exp_lkp_q.push_back({hit, ptr});
        lkp_valid = 1'b1;
        lkp_topic = topic;
        tick();
        lkp_valid = 1'b0;
    endtask

    task automatic exp_upd(input logic [7:0] addr, input logic [31:0] data, input logic hit,
                           input logic [7:0] old_ptr);
        exp_wr_q.push_back({addr, data});
        exp_done_q.push_back(hit);
        if (hit) exp_rel_q.push_back(old_ptr);
        exp_pops++;
    endtask

    // Output monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (free_buf_rd) begin
                pops++;
                chk("rd_while_empty", freeb_empty, 1'b0);
                chk("rd_while_init", freeb_init_done, 1'b1);
            end
            if (val_wr) begin
                chk("wr_expected", exp_wr_q.size() != 0, 1'b1);
                if (exp_wr_q.size() != 0) begin
                    logic [39:0] e;
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", val_wr_addr, e[39:32]);
                    chk("wr_data", val_wr_data, e[31:0]);
                    chk("wr_pop", free_buf_rd, 1'b1);
                end
            end
            if (rel_buf_valid) begin
                chk("rel_expected", exp_rel_q.size() != 0, 1'b1);
                if (exp_rel_q.size() != 0) chk("rel_ptr", rel_buf_ptr, exp_rel_q.pop_front());
            end
            if (req_done) begin
                chk("done_expected", exp_done_q.size() != 0, 1'b1);
                if (exp_done_q.size() != 0) chk("done_hit", req_done_hit, exp_done_q.pop_front());
            end
            if (req_abort) begin
                chk("abort_expected", exp_abort > 0, 1'b1);
                exp_abort--;
            end
            if (lkp_rsp_valid) begin
                chk("lkp_expected", exp_lkp_q.size() != 0, 1'b1);
                if (exp_lkp_q.size() != 0) begin
                    logic [8:0] l;
                    l = exp_lkp_q.pop_front();
                    chk("lkp_hit", lkp_hit, l[8]);
                    chk("lkp_ptr", lkp_ptr, l[7:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 1'b0; req_topic = '0; req_value = '0;
        freeb_init_done = 1'b0; freeb_empty = 1'b1; free_buf_ptr = '0;
        lkp_valid = 1'b0; lkp_topic = '0;
        repeat (3) tick();
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_done", {req_done, req_done_hit, req_abort}, 3'b000);
        chk("rst_rel", {rel_buf_valid, rel_buf_ptr}, 9'h000);
        chk("rst_wr", {free_buf_rd, val_wr, val_wr_addr, val_wr_data}, 42'h0);
        chk("rst_lkp", {lkp_rsp_valid, lkp_hit, lkp_ptr}, 10'h000);
        rst_n = 1'b1;
        tick();

        // First update of topic 3: fresh buffer 0x05, no release.
        freeb_init_done = 1'b1; freeb_empty = 1'b0; free_buf_ptr = 8'h05;
        #1;
        chk("ready_idle", req_ready, 1'b1);
        exp_upd(8'h05, 32'hDEADBEEF, 1'b0, 8'h00);
        send(1'b0, 6'd3, 32'hDEADBEEF);
        chk("ready_exec", req_ready, 1'b0);
        tick();
        chk("ready_after_commit", req_ready, 1'b1);
        free_buf_ptr = 8'h09;
        lookup(6'd3, 1'b1, 8'h05);

        // Re-point topic 3 to 0x09, releasing 0x05.
        exp_upd(8'h09, 32'h12345678, 1'b1, 8'h05);
        send(1'b0, 6'd3, 32'h12345678);
        tick();
        lookup(6'd3, 1'b1, 8'h09);

        // Stall on an empty free list, then a single pop of 0x11.
        freeb_empty = 1'b1; free_buf_ptr = 8'h33;
        exp_upd(8'h11, 32'hCAFEF00D, 1'b1, 8'h09);
        send(1'b0, 6'd3, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++) begin
            chk("stall_ready", req_ready, 1'b0);
            chk("stall_outputs", {free_buf_rd, val_wr, req_done, rel_buf_valid}, 4'b0000);
            tick();
        end
        freeb_empty = 1'b0; free_buf_ptr = 8'h11;
        tick();
        free_buf_ptr = 8'h20;
        lookup(6'd3, 1'b1, 8'h11);

        // Delete hit, then delete miss.
        exp_done_q.push_back(1'b1);
        exp_rel_q.push_back(8'h11);
        send(1'b1, 6'd3, 32'h0);
        tick();
        lookup(6'd3, 1'b0, 8'h00);
        exp_done_q.push_back(1'b0);
        send(1'b1, 6'd3, 32'h0);
        tick();
        chk("rel_ptr_hold", rel_buf_ptr, 8'h11);
        lookup(6'd3, 1'b0, 8'h00);

        // Populate topic 5, then abort a stalled update via free-list reinit.
        exp_upd(8'h20, 32'h55555555, 1'b0, 8'h00);
        send(1'b0, 6'd5, 32'h55555555);
        tick();
        freeb_empty = 1'b1;
        send(1'b0, 6'd5, 32'hAAAAAAAA);
        tick();
        exp_abort++;
        freeb_init_done = 1'b0;
        #1;
        chk("reinit_ready", req_ready, 1'b0);
        chk("reinit_no_pop", {free_buf_rd, val_wr}, 2'b00);
        tick();
        lookup(6'd5, 1'b0, 8'h00);
        lookup(6'd3, 1'b0, 8'h00);
        chk("reinit_ready_held", req_ready, 1'b0);
        chk("abort_seen", exp_abort, 0);
        freeb_init_done = 1'b1; freeb_empty = 1'b0; free_buf_ptr = 8'h02;
        tick();
        lookup(6'd5, 1'b0, 8'h00);

        // Read-before-write: lookup in the commit cycle sees the old pointer.
        exp_upd(8'h02, 32'h00000007, 1'b0, 8'h00);
        send(1'b0, 6'd7, 32'h00000007);
        tick();
        free_buf_ptr = 8'h0A;
        lookup(6'd7, 1'b1, 8'h02);
        exp_upd(8'h0A, 32'h00000077, 1'b1, 8'h02);
        send(1'b0, 6'd7, 32'h00000077);
        lookup(6'd7, 1'b1, 8'h02);
        lookup(6'd7, 1'b1, 8'h0A);

        repeat (3) tick();
        chk("wr_q_drained", exp_wr_q.size(), 0);
        chk("rel_q_drained", exp_rel_q.size(), 0);
        chk("done_q_drained", exp_done_q.size(), 0);
        chk("lkp_q_drained", exp_lkp_q.size(), 0);
        chk("abort_drained", exp_abort, 0);
        chk("pop_count", pops, exp_pops);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
